// File: rtl/imem_loader.sv
// Boot loader: streams a 16-bit word count plus big-endian 32-bit words into instruction memory,
// then releases the core. Optional trailing XOR checksum byte under macro LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_run,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
        CHK    = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_t            state_q;
    logic [7:0]        cnt_hi_q;
    logic [15:0]       count_q;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       part_q;
    logic [ADDR_W-1:0] idx_q;
    logic              in_ready_q;
    logic              im_we_q;
    logic [ADDR_W-1:0] im_addr_q;
    logic [31:0]       im_wdata_q;
    logic              cpu_run_q;
    logic              done_q;
    logic              err_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk_q;
`endif

    // Handshake: a byte moves on a rising edge only when in_valid and in_ready are both 1;
    // in_data is don't-care otherwise, and the sender holds the byte until it is taken.
    logic        take_d;
    logic [15:0] hdr_count_d;
    logic [31:0] word_d;
    logic        last_word_d;

    assign take_d      = in_valid && in_ready_q;
    assign hdr_count_d = {cnt_hi_q, in_data};
    assign word_d      = {part_q, in_data};
    assign last_word_d = (16'(idx_q) == (count_q - 16'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= HDR_HI;
            cnt_hi_q   <= '0;
            count_q    <= '0;
            byte_cnt_q <= '0;
            part_q     <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            cpu_run_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            im_we_q    <= 1'b0;
            in_ready_q <= (state_q != DONE) && (state_q != ERR);
            if (take_d) begin
                case (state_q)
                    HDR_HI: begin
                        cnt_hi_q <= in_data;
                        state_q  <= HDR_LO;
                    end
                    HDR_LO: begin
                        count_q <= hdr_count_d;
                        if ({1'b0, hdr_count_d} > CAP) begin
                            state_q    <= ERR;
                            err_q      <= 1'b1;
                            in_ready_q <= 1'b0;
                        end else if (hdr_count_d == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q    <= CHK;
`else
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            cpu_run_q  <= 1'b1;
                            in_ready_q <= 1'b0;
`endif
                        end else begin
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        part_q     <= word_d[23:0];
`ifdef LOADER_CHECKSUM_EN
                        chk_q      <= chk_q ^ in_data;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            im_we_q    <= 1'b1;
                            im_wdata_q <= word_d;
                            im_addr_q  <= idx_q;
                            // Index is not advanced past the last word, so it never wraps.
                            if (last_word_d) begin
`ifdef LOADER_CHECKSUM_EN
                                state_q    <= CHK;
`else
                                state_q    <= DONE;
                                done_q     <= 1'b1;
                                cpu_run_q  <= 1'b1;
                                in_ready_q <= 1'b0;
`endif
                            end else begin
                                idx_q <= idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CHK: begin
                        in_ready_q <= 1'b0;
                        if (in_data == chk_q) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            cpu_run_q <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign im_we       = im_we_q;
    assign im_addr     = im_addr_q;
    assign im_wdata    = im_wdata_q;
    assign cpu_run     = cpu_run_q;
    assign done        = done_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule
